// File: rtl/btn_pkg.sv
// Shared defaults for the push-button input path (25 MHz system clock)
// and the counter-width helper used by the debounce cells.
package btn_pkg;

  localparam int DEF_NUM_BTN         = 7;
  localparam int DEF_DEBOUNCE_CYCLES = 250000;    // 10 ms at 25 MHz
  localparam int DEF_REPEAT_DELAY    = 12500000;  // 500 ms at 25 MHz
  localparam int DEF_REPEAT_PERIOD   = 2500000;   // 100 ms at 25 MHz

  // Width able to hold 0..n-1, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/btn_debounce_cell.sv
// One button: 2-FF synchroniser, polarity normalisation, stable-sample counter,
// press/release pulses, and auto-repeat of press when BTN_REPEAT_EN is defined.
module btn_debounce_cell
  import btn_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter logic ACTIVE_LOW      = 1'b0,
  parameter int   REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int   REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic level_o,
  output logic level_nxt_o,
  output logic press_o,
  output logic release_o
);

  localparam int              CNT_W    = clog2_min1(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || REPEAT_PERIOD < 1 || REPEAT_PERIOD > REPEAT_DELAY) begin : g_param_check
    $error("btn_debounce_cell: invalid timing parameters");
  end

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             rel_q, rel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             s;
  logic             commit;
  logic             rep_fire;

  always_comb begin
    sync1_d = pin;
    sync2_d = sync1_q;
    s       = sync2_q ^ ACTIVE_LOW;
    cnt_d   = cnt_q;
    level_d = level_q;
    commit  = 1'b0;
    if (s == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      commit  = 1'b1;
      level_d = s;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    press_d = (commit & s) | rep_fire;
    rel_d   = commit & ~s;
  end

`ifdef BTN_REPEAT_EN
  localparam int               REP_W     = clog2_min1(REPEAT_DELAY);
  localparam logic [REP_W-1:0] REP_FIRST = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] REP_NEXT  = REP_W'(REPEAT_PERIOD - 1);

  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
  logic             rep_first_q, rep_first_d;

  // A level change always restarts the repeat timer and wins over a due repeat,
  // so a repeat press can never coincide with a release pulse.
  always_comb begin
    rep_cnt_d   = rep_cnt_q;
    rep_first_d = rep_first_q;
    rep_fire    = 1'b0;
    if (commit) begin
      rep_cnt_d   = '0;
      rep_first_d = 1'b1;
    end else if (level_q) begin
      if (rep_cnt_q == (rep_first_q ? REP_FIRST : REP_NEXT)) begin
        rep_fire    = 1'b1;
        rep_cnt_d   = '0;
        rep_first_d = 1'b0;
      end else begin
        rep_cnt_d = rep_cnt_q + 1'b1;
      end
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      // Synchroniser resets to the idle pin level so an active-low pin does not
      // look like a fresh press the moment reset is released.
      sync1_q <= ACTIVE_LOW;
      sync2_q <= ACTIVE_LOW;
      level_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      cnt_q   <= '0;
`ifdef BTN_REPEAT_EN
      rep_cnt_q   <= '0;
      rep_first_q <= 1'b1;
`endif
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      cnt_q   <= cnt_d;
`ifdef BTN_REPEAT_EN
      rep_cnt_q   <= rep_cnt_d;
      rep_first_q <= rep_first_d;
`endif
    end
  end

  assign level_o     = level_q;
  assign level_nxt_o = reset ? 1'b0 : level_d;
  assign press_o     = press_q;
  assign release_o   = rel_q;

endmodule

// File: rtl/button_debouncer.sv
// Conditions NUM_BTN raw button pins into debounced levels and press/release pulses.
// Auto-repeat of press pulses is built only when BTN_REPEAT_EN is defined.
module button_debouncer
  import btn_pkg::*;
#(
  parameter int                 NUM_BTN         = DEF_NUM_BTN,
  parameter int                 DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter logic [NUM_BTN-1:0] ACTIVE_LOW_MASK = {{(NUM_BTN-1){1'b0}}, 1'b1},
  parameter int                 REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int                 REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] io_btn,
  output logic [NUM_BTN-1:0] io_level,
  output logic [NUM_BTN-1:0] io_press,
  output logic [NUM_BTN-1:0] io_release,
  output logic               io_any
);

  logic [NUM_BTN-1:0] level_nxt;
  logic               any_q, any_d;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BTN; gi++) begin : g_cell
      btn_debounce_cell #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .ACTIVE_LOW      (ACTIVE_LOW_MASK[gi]),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_PERIOD   (REPEAT_PERIOD)
      ) u_cell (
        .clk         (clk),
        .reset       (reset),
        .pin         (io_btn[gi]),
        .level_o     (io_level[gi]),
        .level_nxt_o (level_nxt[gi]),
        .press_o     (io_press[gi]),
        .release_o   (io_release[gi])
      );
    end
  endgenerate

  // Built from the cells' next levels so io_any moves in the same cycle as io_level.
  always_comb begin
    any_d = |level_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      any_q <= 1'b0;
    end else begin
      any_q <= any_d;
    end
  end

  assign io_any = any_q;

endmodule
